// File: rtl/rvfpm_issue_queue.sv
// rvfpm_issue_queue: in-order buffer of instructions offloaded over CORE-V-XIF.
// Each entry waits for its commit verdict. Committed heads are handed to the FPU
// pipeline through a valid/ready handshake. Killed heads are dropped silently.
//
// Ports
//   ck, rst                      clock, asynchronous active-high reset
//   issue_valid/ready/accept     issue handshake; accept also needs dec_accept
//   issue_instr/id/rs0/rs1       issued instruction payload
//   dec_accept                   predecoder verdict for issue_instr
//   commit_valid/id/kill         commit interface
//   disp_valid/ready             dispatch handshake toward the FPU pipeline
//   disp_instr/id/rs0/rs1        head entry payload (zero unless disp_valid)
//   count, full, empty           occupancy status
module rvfpm_issue_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned XLEN        = 32
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [31:0]                  issue_instr,
  input  logic [X_ID_WIDTH-1:0]        issue_id,
  input  logic [XLEN-1:0]              issue_rs0,
  input  logic [XLEN-1:0]              issue_rs1,
  input  logic                         dec_accept,
  output logic                         issue_accept,
  input  logic                         commit_valid,
  input  logic [X_ID_WIDTH-1:0]        commit_id,
  input  logic                         commit_kill,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [31:0]                  disp_instr,
  output logic [X_ID_WIDTH-1:0]        disp_id,
  output logic [XLEN-1:0]              disp_rs0,
  output logic [XLEN-1:0]              disp_rs1,
  output logic [$clog2(QUEUE_DEPTH):0] count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned IW = $clog2(QUEUE_DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_PENDING   = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } entry_state_e;

  entry_state_e            state_q [QUEUE_DEPTH];
  entry_state_e            state_d [QUEUE_DEPTH];
  logic [31:0]             instr_q [QUEUE_DEPTH];
  logic [X_ID_WIDTH-1:0]   id_q    [QUEUE_DEPTH];
  logic [XLEN-1:0]         rs0_q   [QUEUE_DEPTH];
  logic [XLEN-1:0]         rs1_q   [QUEUE_DEPTH];

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]           wr_idx, rd_idx;
  entry_state_e            head_state;
  entry_state_e            commit_state;
  logic                    push;
  logic                    pop;

  // Pointer-derived status; the top pointer bit distinguishes full from empty.
  assign wr_idx     = wr_ptr_q[IW-1:0];
  assign rd_idx     = rd_ptr_q[IW-1:0];
  assign full       = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign count      = wr_ptr_q - rd_ptr_q;

  assign head_state   = state_q[rd_idx];
  assign commit_state = commit_kill ? ST_KILLED : ST_COMMITTED;

  // Handshakes. issue_ready ignores a same-cycle pop to keep the path short.
  assign issue_ready  = !full;
  assign issue_accept = issue_valid && issue_ready && dec_accept && !rst;
  assign push         = issue_accept;
  assign disp_valid   = !empty && (head_state == ST_COMMITTED);
  // A killed head is dropped without a handshake.
  assign pop          = !empty && ((head_state == ST_KILLED) || (disp_valid && disp_ready));

  // Payload is masked to zero whenever nothing is being offered.
  assign disp_instr = disp_valid ? instr_q[rd_idx] : '0;
  assign disp_id    = disp_valid ? id_q[rd_idx]    : '0;
  assign disp_rs0   = disp_valid ? rs0_q[rd_idx]   : '0;
  assign disp_rs1   = disp_valid ? rs1_q[rd_idx]   : '0;

  // Next entry states and pointers: commit broadcast, then push, then pop.
  always_comb begin
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      state_d[IW'(i)] = state_q[IW'(i)];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (commit_valid) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        if ((state_q[IW'(i)] != ST_FREE) && (id_q[IW'(i)] == commit_id)) begin
          state_d[IW'(i)] = commit_state;
        end
      end
    end

    // The target slot is FREE, so the commit loop never touched it.
    if (push) begin
      state_d[wr_idx] = (commit_valid && (commit_id == issue_id)) ? commit_state : ST_PENDING;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    // Push and pop share a slot only when the queue is full or empty, where
    // one of them cannot happen.
    if (pop) begin
      state_d[rd_idx] = ST_FREE;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
  end

  // Control state register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        state_q[IW'(i)] <= ST_FREE;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        state_q[IW'(i)] <= state_d[IW'(i)];
      end
    end
  end

  // Payload storage; validity is carried entirely by state_q.
  always_ff @(posedge ck) begin
    if (push) begin
      instr_q[wr_idx] <= issue_instr;
      id_q[wr_idx]    <= issue_id;
      rs0_q[wr_idx]   <= issue_rs0;
      rs1_q[wr_idx]   <= issue_rs1;
    end
  end

endmodule
